// File: rtl/insertion_sort_buffer.sv
// insertion_sort_buffer: collects a frame, keeps it sorted ascending on every insert, then drains it in order.
// Define SORT_SIGNED_EN for two's-complement ordering; unsigned ordering otherwise.
module insertion_sort_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic {FILL, DRAIN} state_t;
    state_t            state;
    logic [CW-1:0]     rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ins [DEPTH];
    logic [DEPTH-1:0]  sel;
    logic              accept, close, take;
    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SORT_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction
    assign accept   = in_valid && in_ready;
    assign close    = in_last || count == CW'(DEPTH-1);
    assign take     = out_valid && out_ready;
    assign out_last = out_valid && rd_idx == count - CW'(1);
    assign out_data = out_valid ? mem[rd_idx[IW-1:0]] : '0;
    // sel marks the slots from the insertion point up to count; strict > keeps equal keys ahead of the new word
    for (genvar g = 0; g < DEPTH; g++) begin : g_ins
        assign sel[g] = CW'(g) == count || (CW'(g) < count && gt(mem[g], in_data));
        if (g == 0) begin : g_first
            assign ins[g] = sel[g] ? in_data : mem[g];
        end else begin : g_rest
            assign ins[g] = !sel[g] ? mem[g] : sel[g-1] ? mem[g-1] : in_data;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) mem <= ins;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            count     <= '0;
            rd_idx    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == FILL) begin
            in_ready <= !(accept && close);
            if (accept) begin
                count <= count + CW'(1);
                if (close) begin
                    state     <= DRAIN;
                    out_valid <= 1'b1;
                end
            end
        end else if (take) begin
            if (out_last) begin
                state     <= FILL;
                count     <= '0;
                rd_idx    <= '0;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                rd_idx <= rd_idx + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_insertion_sort_buffer.sv
// tb_insertion_sort_buffer: scoreboard bench; expected sorted beats are queued as frames close and popped on each output handshake.
module tb_insertion_sort_buffer;
    localparam int W = 32;
    localparam int D = 32;
    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           c;
    } exp_t;
    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, out_last;
    logic [W-1:0] out_data;
    logic [5:0]   count;
    exp_t         exp_q[$];
    logic [W-1:0] frame[$];
    int           vecs = 0, errs = 0;

    insertion_sort_buffer #(.DATA_W(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORT_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic close_frame();
        logic [W-1:0] a[$];
        logic [W-1:0] t;
        int j;
        a = frame;
        for (int i = 1; i < a.size(); i++) begin
            t = a[i];
            j = i;
            while (j > 0 && lt(t, a[j-1])) begin
                a[j] = a[j-1];
                j--;
            end
            a[j] = t;
        end
        for (int i = 0; i < a.size(); i++)
            exp_q.push_back('{d: a[i], l: (i == a.size() - 1), c: a.size()});
        frame.delete();
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        vecs++;
        if (n >= 100) begin
            errs++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        frame.push_back(d);
        if (l || frame.size() == D) close_frame();
    endtask

    task automatic drain(input bit toggle, input int max_beats);
        bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   cyc = 0, k = 0, beats = 0;
        bit   stalled = 1'b0;
        logic [W-1:0] hold_d;
        logic hold_l;
        exp_t e;
        while (exp_q.size() > 0 && beats < max_beats && cyc < 500) begin
            out_ready = toggle ? pat[k % 4] : 1'b1;
            if (out_valid) begin
                vecs++;
                if (in_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL drain_in_ready: got %b required 0", in_ready);
                end
                if (stalled) begin
                    vecs++;
                    if (out_data !== hold_d || out_last !== hold_l) begin
                        errs++;
                        $display("FAIL stall_hold: data %h last %b required %h %b", out_data, out_last, hold_d, hold_l);
                    end
                end
                if (out_ready) begin
                    e = exp_q.pop_front();
                    vecs++;
                    if (out_data !== e.d || out_last !== e.l || count !== 6'(e.c)) begin
                        errs++;
                        $display("FAIL beat: data %h last %b count %0d required %h %b %0d", out_data, out_last, count, e.d, e.l, e.c);
                    end
                    stalled = 1'b0;
                    beats++;
                end else begin
                    stalled = 1'b1;
                    hold_d  = out_data;
                    hold_l  = out_last;
                end
            end
            k++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        vecs++;
        if (cyc >= 500) begin
            errs++;
            $display("FAIL drain_timeout: %0d beats left", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        vecs++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 || count !== 6'd0) begin
            errs++;
            $display("FAIL reset_state: v=%b l=%b d=%h rdy=%b cnt=%0d required 0 0 0 0 0", out_valid, out_last, out_data, in_ready, count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_release_rdy: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL first_edge_rdy: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic(input bit toggle);
        send(32'd5, 1'b0);
        send(32'd1, 1'b0);
        send(32'd3, 1'b0);
        send(32'd1, 1'b0);
        send(32'd9, 1'b1);
        vecs++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || count !== 6'd5) begin
            errs++;
            $display("FAIL close_latency: v=%b rdy=%b cnt=%0d required 1 0 5", out_valid, in_ready, count);
        end
        drain(toggle, 100);
    endtask

    task automatic test_overflow();
        for (int i = 32; i >= 1; i--) send(W'(i), 1'b0);
        vecs++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || count !== 6'd32) begin
            errs++;
            $display("FAIL overflow_close: v=%b rdy=%b cnt=%0d required 1 0 32", out_valid, in_ready, count);
        end
        drain(1'b0, 100);
        send(32'd0, 1'b1);
        drain(1'b0, 100);
    endtask

    task automatic test_single();
        send(32'd7, 1'b1);
        drain(1'b0, 100);
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 6'd0) begin
            errs++;
            $display("FAIL single_return: rdy=%b v=%b cnt=%0d required 1 0 0", in_ready, out_valid, count);
        end
        @(posedge clk); #1;
        vecs++;
        if (in_ready !== 1'b1 || out_data !== '0) begin
            errs++;
            $display("FAIL single_idle: rdy=%b data=%h required 1 0", in_ready, out_data);
        end
    endtask

    task automatic test_signed();
        send(32'h0000_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        drain(1'b0, 100);
    endtask

    task automatic test_reset_mid_drain();
        send(32'd40, 1'b0);
        send(32'd10, 1'b0);
        send(32'd30, 1'b0);
        send(32'd20, 1'b1);
        drain(1'b0, 2);
        rst = 1'b1;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || count !== 6'd0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_drain_reset: v=%b d=%h l=%b cnt=%0d rdy=%b required 0 0 0 0 0", out_valid, out_data, out_last, count, in_ready);
        end
        exp_q.delete();
        frame.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL post_reset_rdy: got %b required 1", in_ready);
        end
        test_basic(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_overflow();
        test_single();
        test_signed();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
